// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state codes and BCD digit limits for the stopwatch sequencer.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        SW_IDLE  = 2'b00,
        SW_RUN   = 2'b01,
        SW_LAP   = 2'b10,
        SW_PAUSE = 2'b11
    } sw_state_e;

    localparam int SEC_T_MAX = 5;
    localparam int DIGIT_MAX = 9;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and display/status outputs of the stopwatch sequencer.
interface stopwatch_ctrl_if;

    logic        btn_start;
    logic        btn_lap;
    logic        btn_clr;
    logic        tick;
    logic [15:0] disp;
    logic [1:0]  state;
    logic        running;
    logic        sat;

    modport master (
        output btn_start, btn_lap, btn_clr, tick,
        input  disp, state, running, sat
    );

    modport slave (
        input  btn_start, btn_lap, btn_clr, tick,
        output disp, state, running, sat
    );

endinterface

// File: rtl/stopwatch_ctrl_bcd_mod_counter.sv
// Two-digit BCD counter stage; ones roll at MOD_O, the pair wraps to 00 after MAX_VAL.
module bcd_mod_counter #(
    parameter int MOD_O   = 10,
    parameter int MOD_T   = 6,
    parameter int MAX_VAL = MOD_O * MOD_T - 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       at_max,
    output logic       carry_out
);

    localparam logic [3:0] MAX_T = 4'(MAX_VAL / MOD_O);
    localparam logic [3:0] MAX_O = 4'(MAX_VAL % MOD_O);
    localparam logic [3:0] TOP_O = 4'(MOD_O - 1);
    localparam logic [3:0] TOP_T = 4'(MOD_T - 1);

    assign at_max    = (tens == MAX_T) && (ones == MAX_O);
    assign carry_out = inc && at_max;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_max) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == TOP_O) begin
                ones <= '0;
                tens <= (tens == TOP_T) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer owning the MM:SS BCD counter and the display register.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int WRAP    = 1,
    parameter int MAX_MIN = 59
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  sw
);

    sw_state_e   state_q, state_d;
    logic [15:0] count, latch_q, disp_q;
    logic        running_q, sat_q;
    logic [3:0]  sec_t, sec_o, min_t, min_o;
    logic        sec_max, min_max, sec_carry, min_at_unused, min_carry_unused;
    logic        counting, tick_en, at_limit, sat_hit, sec_inc, lap_take;

    // Counting is gated by the registered state so a start pulse never affects its own cycle's tick.
    assign counting = (state_q == SW_RUN) || (state_q == SW_LAP);
    assign tick_en  = sw.tick && !sw.btn_clr && counting;
    assign at_limit = sec_max && min_max;
    assign sat_hit  = (WRAP == 0) && tick_en && at_limit;
    assign sec_inc  = tick_en && !sat_hit;
    assign lap_take = (state_q == SW_RUN) && sw.btn_lap && !sw.btn_start
                      && !sw.btn_clr && !sat_hit;
    assign count    = {min_t, min_o, sec_t, sec_o};
    assign min_at_unused = min_max;

    bcd_mod_counter #(
        .MOD_O(DIGIT_MAX + 1), .MOD_T(SEC_T_MAX + 1)
    ) u_sec (
        .clk(clk), .rst(rst), .clr(sw.btn_clr), .inc(sec_inc),
        .tens(sec_t), .ones(sec_o), .at_max(sec_max), .carry_out(sec_carry)
    );

    bcd_mod_counter #(
        .MOD_O(DIGIT_MAX + 1), .MOD_T(DIGIT_MAX + 1), .MAX_VAL(MAX_MIN)
    ) u_min (
        .clk(clk), .rst(rst), .clr(sw.btn_clr), .inc(sec_carry),
        .tens(min_t), .ones(min_o), .at_max(min_max), .carry_out(min_carry_unused)
    );

    // Priority clr > saturation > start > lap.
    always_comb begin
        state_d = state_q;
        if (sw.btn_clr) begin
            state_d = SW_IDLE;
        end else if (sat_hit) begin
            state_d = SW_PAUSE;
        end else begin
            unique case (state_q)
                SW_IDLE:  if (sw.btn_start) state_d = SW_RUN;
                SW_RUN:   if (sw.btn_start) state_d = SW_PAUSE;
                          else if (sw.btn_lap) state_d = SW_LAP;
                SW_LAP:   if (sw.btn_start) state_d = SW_PAUSE;
                          else if (sw.btn_lap) state_d = SW_RUN;
                SW_PAUSE: if (sw.btn_start) state_d = SW_RUN;
                default:  state_d = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SW_IDLE;
            running_q <= 1'b0;
            sat_q     <= 1'b0;
            latch_q   <= '0;
            disp_q    <= '0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == SW_RUN) || (state_d == SW_LAP);
            sat_q     <= sat_hit;
            if (sw.btn_clr)
                latch_q <= '0;
            else if (lap_take)
                latch_q <= count;
            disp_q    <= (state_q == SW_LAP) ? latch_q : count;
        end
    end

    assign sw.state   = state_q;
    assign sw.running = running_q;
    assign sw.sat     = sat_q;
    assign sw.disp    = disp_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed checks of the stopwatch sequencer: a wrapping instance and a saturating one.
module tb_stopwatch_ctrl;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] LAP   = 2'b10;
    localparam logic [1:0] PAUSE = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    stopwatch_ctrl_if a();
    stopwatch_ctrl_if b();

    stopwatch_ctrl #(.WRAP(1), .MAX_MIN(59)) dut_wrap (.clk(clk), .rst(rst), .sw(a));
    stopwatch_ctrl #(.WRAP(0), .MAX_MIN(1))  dut_sat  (.clk(clk), .rst(rst), .sw(b));

    always #5 clk = ~clk;

    // Drives one cycle of inputs on the selected instance from a negedge to the next negedge.
    task automatic step(input bit sel, input bit s, input bit l, input bit c, input bit t);
        if (!sel) begin
            a.btn_start = s; a.btn_lap = l; a.btn_clr = c; a.tick = t;
        end else begin
            b.btn_start = s; b.btn_lap = l; b.btn_clr = c; b.tick = t;
        end
        @(negedge clk);
        a.btn_start = 0; a.btn_lap = 0; a.btn_clr = 0; a.tick = 0;
        b.btn_start = 0; b.btn_lap = 0; b.btn_clr = 0; b.tick = 0;
    endtask

    task automatic ticks(input bit sel, input int n);
        repeat (n) step(sel, 0, 0, 0, 1);
    endtask

    task automatic idle(input bit sel);
        step(sel, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        a.btn_start = 0; a.btn_lap = 0; a.btn_clr = 0; a.tick = 0;
        b.btn_start = 0; b.btn_lap = 0; b.btn_clr = 0; b.tick = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (a.state !== IDLE) begin errors++; $display("FAIL reset_state got %b exp %b", a.state, IDLE); end
        vectors++; if (a.disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h exp 0000", a.disp); end
        vectors++; if (a.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", a.running); end
        vectors++; if (a.sat !== 1'b0 || b.sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b/%b exp 0/0", a.sat, b.sat); end
        rst = 0;
    endtask

    task automatic test_run;
        step(0, 1, 0, 0, 0);
        vectors++; if (a.state !== RUN || a.running !== 1'b1) begin errors++; $display("FAIL start_latency got %b/%b exp 01/1", a.state, a.running); end
        ticks(0, 3);
        idle(0);
        vectors++; if (a.state !== RUN) begin errors++; $display("FAIL run_state got %b exp %b", a.state, RUN); end
        vectors++; if (a.disp !== 16'h0003) begin errors++; $display("FAIL run_disp got %h exp 0003", a.disp); end
        vectors++; if (a.running !== 1'b1) begin errors++; $display("FAIL run_running got %b exp 1", a.running); end
    endtask

    task automatic test_carry;
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        ticks(0, 59); idle(0);
        vectors++; if (a.disp !== 16'h0059) begin errors++; $display("FAIL carry_0059 got %h exp 0059", a.disp); end
        ticks(0, 1); idle(0);
        vectors++; if (a.disp !== 16'h0100) begin errors++; $display("FAIL carry_0100 got %h exp 0100", a.disp); end
        ticks(0, 539); idle(0);
        vectors++; if (a.disp !== 16'h0959) begin errors++; $display("FAIL carry_0959 got %h exp 0959", a.disp); end
        ticks(0, 1); idle(0);
        vectors++; if (a.disp !== 16'h1000) begin errors++; $display("FAIL carry_1000 got %h exp 1000", a.disp); end
    endtask

    task automatic test_lap;
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        ticks(0, 7);
        step(0, 0, 1, 0, 0); idle(0);
        vectors++; if (a.state !== LAP) begin errors++; $display("FAIL lap_state got %b exp %b", a.state, LAP); end
        vectors++; if (a.disp !== 16'h0007) begin errors++; $display("FAIL lap_freeze got %h exp 0007", a.disp); end
        ticks(0, 5); idle(0);
        vectors++; if (a.disp !== 16'h0007) begin errors++; $display("FAIL lap_held got %h exp 0007", a.disp); end
        step(0, 0, 1, 0, 0); idle(0);
        vectors++; if (a.state !== RUN || a.disp !== 16'h0012) begin errors++; $display("FAIL lap_release got %b/%h exp 01/0012", a.state, a.disp); end
        // lap with a coincident tick latches the pre-increment value
        step(0, 0, 1, 0, 1); idle(0);
        vectors++; if (a.disp !== 16'h0012) begin errors++; $display("FAIL lap_pre_inc got %h exp 0012", a.disp); end
        step(0, 1, 0, 0, 0); idle(0);
        vectors++; if (a.state !== PAUSE || a.disp !== 16'h0013) begin errors++; $display("FAIL lap_to_pause got %b/%h exp 11/0013", a.state, a.disp); end
    endtask

    task automatic test_pause_tick;
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        ticks(0, 4);
        step(0, 1, 0, 0, 1);
        vectors++; if (a.state !== PAUSE || a.running !== 1'b0) begin errors++; $display("FAIL pause_state got %b/%b exp 11/0", a.state, a.running); end
        idle(0);
        vectors++; if (a.disp !== 16'h0005) begin errors++; $display("FAIL pause_counted got %h exp 0005", a.disp); end
        ticks(0, 3); idle(0);
        vectors++; if (a.disp !== 16'h0005) begin errors++; $display("FAIL pause_hold got %h exp 0005", a.disp); end
        step(0, 1, 0, 0, 1); idle(0);
        vectors++; if (a.state !== RUN || a.disp !== 16'h0005) begin errors++; $display("FAIL resume_tick got %b/%h exp 01/0005", a.state, a.disp); end
    endtask

    task automatic test_clr_priority;
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        ticks(0, 150);
        step(0, 1, 1, 1, 0);
        vectors++; if (a.state !== IDLE || a.running !== 1'b0) begin errors++; $display("FAIL clr_state got %b/%b exp 00/0", a.state, a.running); end
        idle(0);
        vectors++; if (a.disp !== 16'h0000) begin errors++; $display("FAIL clr_disp got %h exp 0000", a.disp); end
        ticks(0, 1); idle(0);
        vectors++; if (a.disp !== 16'h0000) begin errors++; $display("FAIL idle_tick got %h exp 0000", a.disp); end
        step(0, 1, 0, 0, 0);
        ticks(0, 2);
        step(0, 0, 0, 1, 1); idle(0);
        vectors++; if (a.disp !== 16'h0000 || a.state !== IDLE) begin errors++; $display("FAIL clr_tick got %h/%b exp 0000/00", a.disp, a.state); end
    endtask

    task automatic test_wrap;
        step(0, 1, 0, 0, 0);
        ticks(0, 3599); idle(0);
        vectors++; if (a.disp !== 16'h5959) begin errors++; $display("FAIL wrap_limit got %h exp 5959", a.disp); end
        ticks(0, 1);
        vectors++; if (a.sat !== 1'b0 || a.state !== RUN) begin errors++; $display("FAIL wrap_state got %b/%b exp 0/01", a.sat, a.state); end
        idle(0);
        vectors++; if (a.disp !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h exp 0000", a.disp); end
    endtask

    task automatic test_saturate;
        step(1, 1, 0, 0, 0);
        ticks(1, 119); idle(1);
        vectors++; if (b.disp !== 16'h0159) begin errors++; $display("FAIL sat_limit got %h exp 0159", b.disp); end
        ticks(1, 1);
        vectors++; if (b.sat !== 1'b1 || b.state !== PAUSE) begin errors++; $display("FAIL sat_pulse got %b/%b exp 1/11", b.sat, b.state); end
        idle(1);
        vectors++; if (b.sat !== 1'b0 || b.disp !== 16'h0159) begin errors++; $display("FAIL sat_hold got %b/%h exp 0/0159", b.sat, b.disp); end
        step(1, 1, 0, 0, 0);
        vectors++; if (b.state !== RUN) begin errors++; $display("FAIL sat_restart got %b exp 01", b.state); end
        ticks(1, 1); idle(1);
        vectors++; if (b.disp !== 16'h0159 || b.state !== PAUSE) begin errors++; $display("FAIL sat_again got %h/%b exp 0159/11", b.disp, b.state); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_carry();
        test_lap();
        test_pause_tick();
        test_clr_priority();
        test_wrap();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
